// File: rtl/img_readout_framer_pkg.sv
// Shared types and helpers for the image readout framer.
package img_readout_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_PIXELS   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_CHECKSUM = 3'd4,
        ST_PADDING  = 3'd5
    } state_e;

    // Checksum goes out as two words; B is sent before A.
    localparam int unsigned CsumWords     = 2;
    localparam bit          CsumHighFirst = 1'b1;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned reg_width(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

    // Pixels emitted per frame for the given mode.
    function automatic int unsigned kept_pixel_count(input int unsigned w, input int unsigned h,
                                                     input int unsigned scale, input bit thumb);
        return thumb ? (2 * w / scale) * (2 * h / scale) : w * h;
    endfunction

endpackage

// File: rtl/img_framer_fletcher.sv
// Fletcher-2W running sums with end-around-carry adders.
module img_framer_fletcher #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] word,
    output logic [W-1:0] sum_a,
    output logic [W-1:0] sum_b
);

    // One's-complement style add modulo 2^W-1, all-ones folded to zero.
    function automatic logic [W-1:0] eac(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] r;
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0] + W'(s[W]);
        return (r == '1) ? '0 : r;
    endfunction

    logic [W-1:0] a_nxt;
    logic [W-1:0] b_nxt;

    assign a_nxt = eac(sum_a, word);
    assign b_nxt = eac(sum_b, a_nxt);

    // Sum registers: clear on frame start, update on each summed fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_a <= '0;
            sum_b <= '0;
        end else if (clr) begin
            sum_a <= '0;
            sum_b <= '0;
        end else if (en) begin
            sum_a <= a_nxt;
            sum_b <= b_nxt;
        end
    end

endmodule

// File: rtl/img_readout_framer.sv
// Frames RAM read data into header + pixels + checksum + padding for the host FIFO.
module img_readout_framer
    import img_readout_framer_pkg::*;
#(
    parameter int unsigned WordWidth        = 16,
    parameter int unsigned ImgWidth         = 2304,
    parameter int unsigned ImgHeight        = 1296,
    parameter int unsigned ThumbScale       = 8,
    parameter int unsigned HeaderWordCount  = 8,
    parameter int unsigned PaddingWordCount = 42
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic                 cmd_thumb,
    input  logic [((HeaderWordCount > 0) ? HeaderWordCount : 1)*WordWidth-1:0] cmd_header,
    input  logic                 src_ready,
    output logic                 src_trigger,
    input  logic [WordWidth-1:0] src_data,
    output logic                 src_stop,
    output logic                 out_ready,
    input  logic                 out_trigger,
    output logic [WordWidth-1:0] out_data,
    output logic                 out_last,
    output logic                 status_busy,
    output logic                 status_done
);

    localparam int unsigned HdrWords = (HeaderWordCount > 0) ? HeaderWordCount : 1;
    localparam int unsigned HdrBits  = HdrWords * WordWidth;
    localparam int unsigned PixTotal = ImgWidth * ImgHeight;
    localparam int unsigned XW       = reg_width(ImgWidth);
    localparam int unsigned YW       = reg_width(ImgHeight);
    localparam int unsigned RemW     = reg_width(PixTotal + 1);
    localparam int unsigned SubW     = reg_width(ThumbScale);
    localparam int unsigned CntMax0  = (HdrWords > PaddingWordCount) ? HdrWords : PaddingWordCount;
    localparam int unsigned CntMax   = (CntMax0 > CsumWords) ? CntMax0 : CsumWords;
    localparam int unsigned CntW     = reg_width(CntMax);

    state_e                 state_q, state_d;
    logic [HdrBits-1:0]     hdr_q, hdr_d;
    logic [2*WordWidth-1:0] csum_q, csum_d;
    logic                   thumb_q, thumb_d;
    logic                   out_sum_q, out_sum_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [RemW-1:0]        rem_q, rem_d;
    logic [WordWidth-1:0]   out_data_d;
    logic                   out_ready_d, out_last_d, busy_d, done_d, stop_d;
    logic                   load_ok, fire, keep, consume, fl_clr, fl_en;
    logic [WordWidth-1:0]   sum_a, sum_b;

    assign load_ok     = !out_ready || out_trigger;
    assign fire        = out_ready && out_trigger;
    assign keep        = !thumb_q ||
                         (({1'b0, x_q[SubW-1:0]} < (SubW+1)'(2)) &&
                          ({1'b0, y_q[SubW-1:0]} < (SubW+1)'(2)));
    assign src_trigger = (state_q == ST_PIXELS) && (rem_q != '0) && (!keep || load_ok);
    assign consume     = src_trigger && src_ready;
    assign fl_en       = fire && out_sum_q;

    img_framer_fletcher #(.W(WordWidth)) u_fletcher (
        .clk   (clk),
        .rst   (rst),
        .clr   (fl_clr),
        .en    (fl_en),
        .word  (out_data),
        .sum_a (sum_a),
        .sum_b (sum_b)
    );

    // Next-state, counters and holding-register loads.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        csum_d      = csum_q;
        thumb_d     = thumb_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        rem_d       = rem_q;
        out_data_d  = out_data;
        out_ready_d = out_ready && !out_trigger;
        out_last_d  = fire ? 1'b0 : out_last;
        out_sum_d   = out_sum_q;
        busy_d      = status_busy && !(fire && out_last);
        done_d      = fire && out_last;
        stop_d      = 1'b0;
        fl_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start && !status_busy) begin
                    hdr_d   = cmd_header;
                    thumb_d = cmd_thumb;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    rem_d   = RemW'(PixTotal);
                    fl_clr  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = (HeaderWordCount > 0) ? ST_HEADER : ST_PIXELS;
                end
            end
            ST_HEADER: begin
                if (load_ok) begin
                    out_ready_d = 1'b1;
                    out_data_d  = hdr_q[HdrBits-1 -: WordWidth];
                    out_last_d  = 1'b0;
                    out_sum_d   = 1'b1;
                    hdr_d       = hdr_q << WordWidth;
                    cnt_d       = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(HeaderWordCount - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PIXELS;
                    end
                end
            end
            ST_PIXELS: begin
                if (consume) begin
                    rem_d = rem_q - RemW'(1);
                    if (x_q == XW'(ImgWidth - 1)) begin
                        x_d = '0;
                        y_d = (y_q == YW'(ImgHeight - 1)) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (keep) begin
                        out_ready_d = 1'b1;
                        out_data_d  = src_data;
                        out_last_d  = 1'b0;
                        out_sum_d   = 1'b1;
                    end
                    if (rem_q == RemW'(1)) begin
                        stop_d  = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_ready) begin
                    csum_d  = CsumHighFirst ? {sum_b, sum_a} : {sum_a, sum_b};
                    cnt_d   = '0;
                    state_d = ST_CHECKSUM;
                end
            end
            ST_CHECKSUM: begin
                if (load_ok) begin
                    out_ready_d = 1'b1;
                    out_data_d  = csum_q[2*WordWidth-1 -: WordWidth];
                    out_last_d  = (cnt_q == CntW'(CsumWords - 1)) && (PaddingWordCount == 0);
                    out_sum_d   = 1'b0;
                    csum_d      = csum_q << WordWidth;
                    cnt_d       = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(CsumWords - 1)) begin
                        cnt_d   = '0;
                        state_d = (PaddingWordCount > 0) ? ST_PADDING : ST_IDLE;
                    end
                end
            end
            ST_PADDING: begin
                if (load_ok) begin
                    out_ready_d = 1'b1;
                    out_data_d  = '0;
                    out_last_d  = (cnt_q == CntW'(PaddingWordCount - 1));
                    out_sum_d   = 1'b0;
                    cnt_d       = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(PaddingWordCount - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            csum_q      <= '0;
            thumb_q     <= 1'b0;
            out_sum_q   <= 1'b0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rem_q       <= '0;
            out_data    <= '0;
            out_ready   <= 1'b0;
            out_last    <= 1'b0;
            status_busy <= 1'b0;
            status_done <= 1'b0;
            src_stop    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            csum_q      <= csum_d;
            thumb_q     <= thumb_d;
            out_sum_q   <= out_sum_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rem_q       <= rem_d;
            out_data    <= out_data_d;
            out_ready   <= out_ready_d;
            out_last    <= out_last_d;
            status_busy <= busy_d;
            status_done <= done_d;
            src_stop    <= stop_d;
        end
    end

endmodule

// File: tb/tb_img_readout_framer.sv
// Self-checking bench for img_readout_framer against a frame-level reference model.
module tb_img_readout_framer;

    localparam int W    = 16;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int TS   = 4;
    localparam int HW   = 2;
    localparam int PW   = 3;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic          cmd_thumb;
    logic [HW*W-1:0] cmd_header;
    logic          src_ready;
    logic          src_trigger;
    logic [W-1:0]  src_data;
    logic          src_stop;
    logic          out_ready;
    logic          out_trigger;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          status_busy;
    logic          status_done;

    img_readout_framer #(
        .WordWidth(W), .ImgWidth(IW), .ImgHeight(IH), .ThumbScale(TS),
        .HeaderWordCount(HW), .PaddingWordCount(PW)
    ) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_thumb(cmd_thumb),
        .cmd_header(cmd_header), .src_ready(src_ready), .src_trigger(src_trigger),
        .src_data(src_data), .src_stop(src_stop), .out_ready(out_ready),
        .out_trigger(out_trigger), .out_data(out_data), .out_last(out_last),
        .status_busy(status_busy), .status_done(status_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] pix [NPIX];
    logic [W-1:0] exp_data [$];
    bit           exp_last [$];
    logic [W-1:0] got_data [$];
    bit           got_last [$];

    int          src_idx, done_cnt, stop_cnt, viol_cnt, cyc;
    int          busy_start_at = -1;
    int unsigned sink_pct, src_pct;
    bit          cur_thumb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected frame: header, kept pixels, Fletcher sums mod 65535, zero padding.
    task automatic build_expected(input bit thumb, input logic [W-1:0] h0, input logic [W-1:0] h1);
        int a = 0;
        int b = 0;
        logic [W-1:0] body [$];
        body.push_back(h0);
        body.push_back(h1);
        for (int i = 0; i < NPIX; i++) begin
            int x = i % IW;
            int y = i / IW;
            if (!thumb || ((x % TS) < 2 && (y % TS) < 2)) body.push_back(pix[i]);
        end
        exp_data.delete();
        exp_last.delete();
        foreach (body[i]) begin
            a = (a + int'(body[i])) % 65535;
            b = (b + a) % 65535;
            exp_data.push_back(body[i]);
        end
        exp_data.push_back(W'(b));
        exp_data.push_back(W'(a));
        for (int i = 0; i < PW; i++) exp_data.push_back('0);
        foreach (exp_data[i]) exp_last.push_back(i == exp_data.size() - 1);
    endtask

    // One clock: random handshakes, then record the fire/consume that the next edge performs.
    task automatic cycle_step();
        @(negedge clk);
        done_cnt   += int'(status_done);
        stop_cnt   += int'(src_stop);
        cmd_start   = (cyc == busy_start_at);
        cmd_thumb   = ~cur_thumb;
        cmd_header  = 32'hDEAD_BEEF;
        out_trigger = ($urandom_range(99) < sink_pct);
        src_ready   = ($urandom_range(99) < src_pct);
        src_data    = (src_idx < NPIX) ? pix[6'(src_idx)] : '0;
        #1;
        if (out_ready && out_trigger) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (src_ready && src_trigger) begin
            if (!cur_thumb && out_ready && !out_trigger) viol_cnt++;
            src_idx++;
        end
        cyc++;
    endtask

    task automatic start_frame(input bit thumb, input logic [W-1:0] h0, input logic [W-1:0] h1);
        @(negedge clk);
        cmd_start   = 1'b1;
        cmd_thumb   = thumb;
        cmd_header  = {h0, h1};
        out_trigger = 1'b0;
        src_ready   = 1'b0;
        cur_thumb   = thumb;
        src_idx     = 0;
        done_cnt    = 0;
        stop_cnt    = 0;
        viol_cnt    = 0;
        cyc         = 0;
        got_data.delete();
        got_last.delete();
        build_expected(thumb, h0, h1);
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        check("busy after start", 32'(status_busy), 32'd1);
    endtask

    task automatic finish_frame(input string tag);
        int budget = 3000;
        while (done_cnt == 0 && budget > 0) begin
            cycle_step();
            budget--;
        end
        check({tag, " done within budget"}, 32'(budget > 0), 32'd1);
        repeat (4) cycle_step();
        check({tag, " word count"}, 32'(got_data.size()), 32'(exp_data.size()));
        foreach (exp_data[i]) begin
            check($sformatf("%s word %0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
            check($sformatf("%s last %0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
        end
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " stop pulses"}, 32'(stop_cnt), 32'd1);
        check({tag, " src consumed"}, 32'(src_idx), 32'(NPIX));
        check({tag, " consume while full"}, 32'(viol_cnt), 32'd0);
        check({tag, " busy at end"}, 32'(status_busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " out_ready"},   32'(out_ready),   32'd0);
        check({tag, " out_data"},    32'(out_data),    32'd0);
        check({tag, " out_last"},    32'(out_last),    32'd0);
        check({tag, " status_busy"}, 32'(status_busy), 32'd0);
        check({tag, " status_done"}, 32'(status_done), 32'd0);
        check({tag, " src_stop"},    32'(src_stop),    32'd0);
        check({tag, " src_trigger"}, 32'(src_trigger), 32'd0);
    endtask

    initial begin
        int kept [16] = '{0, 1, 4, 5, 8, 9, 12, 13, 32, 33, 36, 37, 40, 41, 44, 45};
        logic [W-1:0] rh0, rh1;
        int budget;

        rst = 1'b1; cmd_start = 1'b0; cmd_thumb = 1'b0; cmd_header = '0;
        src_ready = 1'b0; src_data = '0; out_trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Full frame, zero pixels, sink always ready.
        foreach (pix[i]) pix[i] = '0;
        sink_pct = 100; src_pct = 100;
        start_frame(1'b0, 16'h0001, 16'h0002);
        finish_frame("t1");
        check("t1 sum B", 32'(got_data[66]), 32'h00C4);
        check("t1 sum A", 32'(got_data[67]), 32'h0003);
        check("t1 last flag", 32'(got_last[70]), 32'd1);

        // Thumbnail with ramp pixels.
        foreach (pix[i]) pix[i] = W'(i);
        start_frame(1'b1, 16'h0001, 16'h0002);
        finish_frame("t2");
        for (int k = 0; k < 16; k++)
            check($sformatf("t2 thumb pixel %0d", k), 32'(got_data[2 + k]), 32'(kept[k]));

        // Modular wrap in the sums.
        foreach (pix[i]) pix[i] = '0;
        start_frame(1'b0, 16'hFFFE, 16'h0002);
        finish_frame("t3");
        check("t3 sum A", 32'(got_data[67]), 32'h0001);
        check("t3 B not all-ones", 32'(got_data[66] != 16'hFFFF), 32'd1);
        check("t3 A not all-ones", 32'(got_data[67] != 16'hFFFF), 32'd1);

        // Random handshakes, both modes, random data.
        sink_pct = 50; src_pct = 70;
        for (int m = 0; m < 2; m++) begin
            foreach (pix[i]) pix[i] = W'($urandom);
            rh0 = W'($urandom); rh1 = W'($urandom);
            start_frame(m[0], rh0, rh1);
            finish_frame(m == 0 ? "t4 full" : "t4 thumb");
        end

        // Reset mid-Pixels, then a clean frame.
        foreach (pix[i]) pix[i] = W'($urandom);
        rh0 = W'($urandom); rh1 = W'($urandom);
        start_frame(1'b0, rh0, rh1);
        budget = 1000;
        while (src_idx < 20 && budget > 0) begin
            cycle_step();
            budget--;
        end
        check("t5 reached pixels", 32'(budget > 0), 32'd1);
        @(negedge clk);
        rst = 1'b1; out_trigger = 1'b0; src_ready = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("t5 after rst");
        rst = 1'b0;
        sink_pct = 100; src_pct = 100;
        start_frame(1'b0, rh0, rh1);
        finish_frame("t5 clean");

        // cmd_start with rst, and cmd_start while busy.
        @(negedge clk);
        rst = 1'b1; cmd_start = 1'b1; cmd_thumb = 1'b1;
        @(posedge clk);
        #1;
        check("t6 start with rst busy", 32'(status_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0; cmd_start = 1'b0;
        @(posedge clk);
        #1;
        check("t6 idle after rst", 32'(status_busy), 32'd0);
        sink_pct = 60; src_pct = 80;
        busy_start_at = 10;
        start_frame(1'b1, 16'h1234, 16'h5678);
        finish_frame("t6");
        busy_start_at = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
